// File: rtl/dm_access_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_access_if
//  Description : Request/response and data-memory bus bundle for the
//                load/store access unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_access_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // System side: CPU memory stage plus the data memory
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    // Access unit side
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dm_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : dm_access_unit
//  Description : Multi-cycle load/store unit for a synchronous-read memory
//                without byte enables. Sub-word loads are extracted and
//                extended; partial stores use read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    dm_access_if.slave   bus
);
    localparam int                LB        = $clog2(DATA_W / 8);
    localparam logic [1:0]        LB_SIZE   = 2'(LB);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(DATA_W / 8 - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [LB-1:0]     r_lane;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_line;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [ADDR_W-1:0] r_mem_addr;

    logic              w_accept;
    logic [2:0]        w_misalign;
    logic              w_req_err;
    logic [LB+2:0]     w_shamt;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_sign_bit;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_lane_mask;
    logic [DATA_W-1:0] w_merge;

    assign w_accept   = bus.req_valid && (r_state == IDLE);
    // Any set address bit below the access size means misalignment
    assign w_misalign = bus.req_addr[2:0] & ((3'd1 << bus.req_size) - 3'd1);
    assign w_req_err  = (bus.req_size > LB_SIZE) || (w_misalign != 3'd0);
    assign w_shamt    = {r_lane, 3'b000};

    // Low-aligned mask covering the registered access size
    always_comb begin
        case (r_size)
            2'd0:    w_mask = DATA_W'(8'hFF);
            2'd1:    w_mask = DATA_W'(16'hFFFF);
            2'd2:    w_mask = DATA_W'(32'hFFFF_FFFF);
            default: w_mask = '1;
        endcase
    end

    // Load extraction works on the live read data so the result is ready
    // at the CAP->RESP edge; the sign bit is the top bit of the size mask.
    assign w_sign_bit  = w_mask & ~(w_mask >> 1);
    assign w_shifted   = bus.mem_rdata >> w_shamt;
    assign w_load      = (r_uns || ((w_shifted & w_sign_bit) == '0))
                       ? (w_shifted & w_mask) : (w_shifted | ~w_mask);
    assign w_lane_mask = w_mask << w_shamt;
    assign w_merge     = (r_line & ~w_lane_mask) | ((r_wdata & w_mask) << w_shamt);

    // State register; async reset drops the memory strobes immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and strobe decode
    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = '0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_req_err)                                w_next = RESP;
                    else if (bus.req_we && bus.req_size == LB_SIZE) w_next = WR;
                    else                                          w_next = RD;
                end
            end
            RD: begin
                bus.mem_en = 1'b1;
                w_next     = CAP;
            end
            CAP: w_next = r_we ? WR : RESP;
            WR: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = (r_size == LB_SIZE) ? r_wdata : w_merge;
                w_next        = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                w_next         = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture, line capture and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_uns      <= 1'b0;
            r_lane     <= '0;
            r_wdata    <= '0;
            r_line     <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_size     <= bus.req_size;
                r_uns      <= bus.req_unsigned;
                r_lane     <= bus.req_addr[LB-1:0];
                r_wdata    <= bus.req_wdata;
                r_mem_addr <= bus.req_addr & ~LANE_MASK;
            end
            if (r_state == CAP) begin
                r_line <= bus.mem_rdata;
            end
            // Response fields only move on the edge that enters RESP
            if (w_accept && w_req_err) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end else if (r_state == CAP && !r_we) begin
                r_rdata <= w_load;
                r_err   <= 1'b0;
            end else if (r_state == WR) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.mem_addr   = r_mem_addr;
endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_access_unit
//  Description : Directed self-checking bench for dm_access_unit, with a
//                32-bit and a 64-bit instance sharing one stimulus bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_access_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
    dm_access_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

    dm_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    dm_access_unit #(.DATA_W(64), .ADDR_W(32)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

    // Shared request drive; valid is per instance
    logic        sel, v32, v64, t_we, t_uns;
    logic [1:0]  t_size;
    logic [31:0] t_addr;
    logic [63:0] t_wdata;

    assign b32.req_valid    = v32;
    assign b32.req_we       = t_we;
    assign b32.req_size     = t_size;
    assign b32.req_unsigned = t_uns;
    assign b32.req_addr     = t_addr;
    assign b32.req_wdata    = t_wdata[31:0];
    assign b64.req_valid    = v64;
    assign b64.req_we       = t_we;
    assign b64.req_size     = t_size;
    assign b64.req_unsigned = t_uns;
    assign b64.req_addr     = t_addr;
    assign b64.req_wdata    = t_wdata;

    // Memory models: synchronous read, one cycle latency
    logic [31:0] mem32 [0:255];
    logic [63:0] mem64 [0:255];
    always @(posedge clk) begin
        if (b32.mem_en && !b32.mem_we) b32.mem_rdata <= mem32[b32.mem_addr[9:2]];
        if (b32.mem_en &&  b32.mem_we) mem32[b32.mem_addr[9:2]] <= b32.mem_wdata;
        if (b64.mem_en && !b64.mem_we) b64.mem_rdata <= mem64[b64.mem_addr[10:3]];
        if (b64.mem_en &&  b64.mem_we) mem64[b64.mem_addr[10:3]] <= b64.mem_wdata;
    end

    // Observation mux for the selected instance
    logic        o_ready, o_rv, o_err, o_en, o_we;
    logic [63:0] o_rdata, o_wdata;
    logic [31:0] o_addr;
    always_comb begin
        o_ready = sel ? b64.req_ready  : b32.req_ready;
        o_rv    = sel ? b64.resp_valid : b32.resp_valid;
        o_err   = sel ? b64.resp_err   : b32.resp_err;
        o_en    = sel ? b64.mem_en     : b32.mem_en;
        o_we    = sel ? b64.mem_we     : b32.mem_we;
        o_rdata = sel ? b64.resp_rdata : {32'd0, b32.resp_rdata};
        o_wdata = sel ? b64.mem_wdata  : {32'd0, b32.mem_wdata};
        o_addr  = sel ? b64.mem_addr   : b32.mem_addr;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-transaction observations, latencies counted from the accept cycle
    logic [63:0] lat, rdata, err, rd_cnt, rd_lat, rd_addr, wr_cnt, wr_lat, wr_data, wr_addr;

    task automatic xact(input logic s, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [63:0] wdata);
        @(negedge clk);
        sel = s; t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wdata;
        if (s) v64 = 1'b1; else v32 = 1'b1;
        lat = 0; rdata = 0; err = 0; rd_cnt = 0; rd_lat = 0; rd_addr = 0;
        wr_cnt = 0; wr_lat = 0; wr_data = 0; wr_addr = 0;
        @(posedge clk);
        #1;
        v32 = 1'b0; v64 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (o_en && !o_we) begin rd_cnt++; rd_lat = 64'(k); rd_addr = {32'd0, o_addr}; end
            if (o_en &&  o_we) begin wr_cnt++; wr_lat = 64'(k); wr_data = o_wdata; wr_addr = {32'd0, o_addr}; end
            if (o_rv) begin lat = 64'(k); rdata = o_rdata; err = {63'd0, o_err}; break; end
        end
    endtask

    int acc, acc_k, rv_n, rv2_k, wr_n, rv_seen;
    logic [63:0] rd1, rd2;

    initial begin
        sel = 0; v32 = 0; v64 = 0; t_we = 0; t_uns = 0; t_size = 0; t_addr = 0; t_wdata = 0;
        repeat (2) @(negedge clk);
        check("rst.ready", {63'd0, o_ready}, 64'd1);
        check("rst.rv",    {63'd0, o_rv},    64'd0);
        check("rst.en",    {63'd0, o_en},    64'd0);
        check("rst.addr",  {32'd0, o_addr},  64'd0);
        check("rst.wdata", o_wdata,          64'd0);
        check("rst.rdata", o_rdata,          64'd0);
        check("rst.err",   {63'd0, o_err},   64'd0);
        rst_n = 1'b1;

        // Full-width stores: single write at N+1, resp at N+2
        xact(0, 1, 2'd2, 0, 32'h100, 64'h8180_7F01);
        check("sw0.lat", lat, 64'd2);
        check("sw0.wr_lat", wr_lat, 64'd1);
        check("sw0.rd_cnt", rd_cnt, 64'd0);
        xact(0, 1, 2'd2, 0, 32'h104, 64'hDEAD_BEEF);
        check("sw4.lat", lat, 64'd2);
        check("sw4.wr_cnt", wr_cnt, 64'd1);
        check("sw4.wr_addr", wr_addr, 64'h104);
        check("sw4.wr_data", wr_data, 64'hDEAD_BEEF);
        check("sw4.rd_cnt", rd_cnt, 64'd0);

        // Loads
        xact(0, 0, 2'd0, 0, 32'h103, 0);
        check("lb.lat", lat, 64'd3);
        check("lb.rd_lat", rd_lat, 64'd1);
        check("lb.rd_addr", rd_addr, 64'h100);
        check("lb.rdata", rdata, 64'hFFFF_FF81);
        check("lb.wr_cnt", wr_cnt, 64'd0);
        @(negedge clk);
        check("lb.hold_rdata", o_rdata, 64'hFFFF_FF81);
        check("lb.rv_pulse", {63'd0, o_rv}, 64'd0);
        xact(0, 0, 2'd0, 1, 32'h103, 0);
        check("lbu.rdata", rdata, 64'h81);
        xact(0, 0, 2'd1, 0, 32'h102, 0);
        check("lh.rdata", rdata, 64'hFFFF_8180);
        xact(0, 0, 2'd1, 1, 32'h100, 0);
        check("lhu.rdata", rdata, 64'h7F01);
        xact(0, 0, 2'd2, 0, 32'h100, 0);
        check("lw.rdata", rdata, 64'h8180_7F01);
        check("lw.err", err, 64'd0);

        // Partial store: read N+1, write N+3, resp N+4
        xact(0, 1, 2'd0, 0, 32'h101, 64'h1234_56AA);
        check("sb.rd_lat", rd_lat, 64'd1);
        check("sb.wr_lat", wr_lat, 64'd3);
        check("sb.wr_data", wr_data, 64'h8180_AA01);
        check("sb.lat", lat, 64'd4);
        check("sb.rdata", rdata, 64'd0);
        xact(0, 0, 2'd2, 0, 32'h100, 0);
        check("sb.readback", rdata, 64'h8180_AA01);

        // Errors
        xact(0, 0, 2'd1, 0, 32'h101, 0);
        check("mis.err", err, 64'd1);
        check("mis.lat", lat, 64'd1);
        check("mis.rdata", rdata, 64'd0);
        check("mis.mem", rd_cnt + wr_cnt, 64'd0);
        xact(0, 0, 2'd3, 0, 32'h100, 0);
        check("sz3.err", err, 64'd1);
        check("sz3.lat", lat, 64'd1);

        // 64-bit instance
        xact(1, 1, 2'd3, 0, 32'h108, 64'h1122_3344_5566_7788);
        check("sd.lat", lat, 64'd2);
        xact(1, 1, 2'd1, 0, 32'h10E, 64'hBEEF);
        check("sh64.wr_addr", wr_addr, 64'h108);
        check("sh64.wr_data", wr_data, 64'hBEEF_3344_5566_7788);
        check("sh64.lat", lat, 64'd4);
        xact(1, 0, 2'd2, 0, 32'h10C, 0);
        check("lw64.rdata", rdata, 64'hFFFF_FFFF_BEEF_3344);
        xact(1, 0, 2'd3, 0, 32'h108, 0);
        check("ld64.rdata", rdata, 64'hBEEF_3344_5566_7788);

        // Reset during CAP of a byte store
        @(negedge clk);
        sel = 0; t_we = 1; t_size = 2'd0; t_uns = 0; t_addr = 32'h100; t_wdata = 64'h77; v32 = 1;
        @(posedge clk);
        #1 v32 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid.en", {63'd0, o_en}, 64'd0);
        check("rstmid.ready", {63'd0, o_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wr_n = 0; rv_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o_en && o_we) wr_n++;
            if (o_rv) rv_seen++;
        end
        check("rstmid.writes", 64'(wr_n), 64'd0);
        check("rstmid.resp", 64'(rv_seen), 64'd0);
        check("rstmid.ready_after", {63'd0, o_ready}, 64'd1);
        xact(0, 0, 2'd2, 0, 32'h100, 0);
        check("rstmid.mem_kept", rdata, 64'h8180_AA01);

        // Request held through a busy period
        @(negedge clk);
        sel = 0; t_we = 0; t_size = 2'd2; t_uns = 0; t_addr = 32'h104; v32 = 1;
        @(posedge clk);
        #1 v32 = 0;
        acc = 0; acc_k = 0; rv_n = 0; rv2_k = 0; rd1 = 0; rd2 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin t_addr = 32'h100; v32 = 1; end
            if (o_rv) begin
                rv_n++;
                if (rv_n == 1) rd1 = o_rdata;
                else begin rd2 = o_rdata; rv2_k = k; end
            end
            if (o_ready && v32) begin
                acc++; acc_k = k;
                @(posedge clk);
                #1 v32 = 0;
            end
        end
        check("hold.accepts", 64'(acc), 64'd1);
        check("hold.accept_cycle", 64'(acc_k), 64'd4);
        check("hold.resp_count", 64'(rv_n), 64'd2);
        check("hold.rdata1", rd1, 64'hDEAD_BEEF);
        check("hold.resp2_cycle", 64'(rv2_k), 64'd7);
        check("hold.rdata2", rd2, 64'h8180_AA01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dm_access_unit.md
# dm_access_unit

Multi-cycle load/store unit between the CPU's memory stage and a single-port, synchronous-read data memory that has no byte enables. It generalises sub-word access to any power-of-two data width: byte, half, word and (for 64-bit) double accesses, signed or unsigned loads, and read-modify-write for partial stores. It also flags misaligned or oversize requests. A valid/ready request handshake stalls the pipeline for the duration of each access.

## Interface
- DATA_W, 32, memory/data width in bits; 32 or 64
- ADDR_W, 32, byte-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  log2(bytes): 0 byte, 1 half, 2 word, 3 double
- req_unsigned  in  1  zero-extend a load (otherwise sign-extend)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or unsupported size; valid with resp_valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  byte address with the low LB bits zero; LB = log2(DATA_W/8)
- mem_wdata  out  DATA_W  full-width write data
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after a read strobe

## Operation
- FSM states: IDLE, RD, CAP, WR, RESP. req_ready = (state == IDLE).
- Accept: req_valid & req_ready at a rising edge. On accept, the unit registers we, size, unsigned, addr and wdata. Requests that arrive while not ready are ignored; the requester must hold them.
- Error check at accept: error if size > LB, or if addr[size-1:0] != 0. An error request goes IDLE→RESP with resp_err=1 and resp_rdata=0, and makes no memory access.
- Load: IDLE→RD→CAP→RESP.
- Full-width store (size == LB): IDLE→WR→RESP. No read is issued. mem_wdata = wdata.
- Partial store: IDLE→RD→CAP→WR→RESP.
- RD: mem_en=1, mem_we=0. CAP: capture mem_rdata into a line register. WR: mem_en=1, mem_we=1.
- Lane: lane = addr[LB-1:0].
- Load extraction: shifted = line >> (8·lane); keep the low 8·2^size bits, then sign- or zero-extend to DATA_W.
- Store merge: mem_wdata equals the line with bytes lane..lane+2^size-1 replaced by the low 2^size bytes of wdata. All other bytes are unchanged.
- RESP: resp_valid=1 for exactly one cycle with no backpressure, then the FSM returns to IDLE.
- mem_addr holds the registered address with the low LB bits cleared. Outside RD/WR it holds its last value. mem_en=0 outside RD/WR.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, all internal registers 0.
- Request accepted at the edge ending cycle N. resp_valid is high in:
  - error: N+1
  - full store: N+2
  - load: N+3
  - partial store: N+4
- Memory strobes:
  - read strobe in N+1
  - full-store write in N+1
  - partial-store write in N+3
- Throughput: the next accept is possible no earlier than the IDLE cycle after RESP. There is at least one idle cycle between consecutive responses.
- Reset mid-operation: the state returns to IDLE immediately and mem_en/mem_we drop asynchronously. No write is issued after reset deasserts. A pending response is discarded.
- resp_rdata and resp_err change only when entering RESP. They hold their values until the next RESP.
- req_valid during RESP is not accepted until IDLE.

## Test plan
Memory word at 0x100 = 0x8180_7F01 unless stated. DATA_W=32 unless stated.
1. LB 0x103 signed → resp_rdata 0xFFFF_FF81 at N+3, read strobe at N+1 with mem_addr 0x100. LBU 0x103 → 0x0000_0081.
2. LH 0x102 signed → 0xFFFF_8180. LHU 0x100 → 0x0000_7F01. LW 0x100 → 0x8180_7F01.
3. SB 0x101, wdata 0x1234_56AA → read at N+1, write at N+3 with mem_wdata 0x8180_AA01, resp at N+4 with rdata 0. A following LW 0x100 returns 0x8180_AA01.
4. SW 0x104, wdata 0xDEAD_BEEF → single write at N+1 with no read strobe, resp at N+2.
5. Error cases:
   - LH 0x101 → resp_err=1 at N+1, rdata 0, mem_en never asserted.
   - size 3 with DATA_W=32 → resp_err=1.
   - DATA_W=64: SH 0x10E, wdata 0xBEEF → mem_addr 0x108, bytes 6–7 replaced, all other bytes kept.
6. Reset and handshake:
   - rst_n low during CAP of an SB → no write strobe; after release req_ready=1, resp_valid=0.
   - req_valid held through a busy period → accepted exactly once, on the first IDLE cycle.
